// File: rtl/ar_pkg.sv
// ar_pkg: state encoding, default timing and sizing helpers shared by the auto-repeat controller.
package ar_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_PRESS, S_HOLD, S_AUTO, S_REP, S_AUTO_L, S_REP_L, S_STOP
    } ar_state_t;
    localparam int DEF_HOLD_CYC = 8;
    localparam int DEF_SLOW_CYC = 4;
    localparam int DEF_FAST_CYC = 2;
    localparam int DEF_ACCEL_N  = 3;
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/ar_channel.sv
// ar_channel: one button channel -- press/hold/auto-repeat FSM with latched repeat and accelerating period.
module ar_channel
    import ar_pkg::*;
#(
    parameter int N_TGT    = 2,
    parameter int SEL_W    = 1,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int SLOW_CYC = DEF_SLOW_CYC,
    parameter int FAST_CYC = DEF_FAST_CYC,
    parameter int ACCEL_N  = DEF_ACCEL_N,
    parameter int LATCH_EN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_carry,
    output logic [N_TGT-1:0] o_up,
    output logic             o_auto_on
);
    localparam int CNT_W = clog2_min1(max3(HOLD_CYC, SLOW_CYC, FAST_CYC));
    localparam int REP_W = clog2_min1(ACCEL_N + 1);

    ar_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [REP_W-1:0] r_rep;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] w_lim;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [REP_W-1:0] w_rep_nx;
    logic             w_hit;
    logic             w_pulse;

    // HOLD times the initial delay; the repeat states use the slow/fast period.
    assign w_lim = (r_state == S_HOLD) ? CNT_W'(HOLD_CYC - 1)
                 : (r_rep < REP_W'(ACCEL_N)) ? CNT_W'(SLOW_CYC - 1) : CNT_W'(FAST_CYC - 1);
    assign w_hit     = r_cnt == w_lim;
    assign w_cnt_nx  = w_hit ? '0 : r_cnt + 1'b1;
    assign w_rep_nx  = (r_rep == REP_W'(ACCEL_N)) ? r_rep : r_rep + 1'b1;
    assign w_pulse   = r_state inside {S_PRESS, S_REP, S_REP_L};
    assign o_auto_on = r_state inside {S_AUTO, S_REP, S_AUTO_L, S_REP_L};

    for (genvar t = 0; t < N_TGT; t++) begin : g_tgt
        assign o_up[t] = (w_pulse && r_sel == SEL_W'(t)) || (t == 0 && i_carry && !o_auto_on);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_btn) begin
                    r_state <= S_PRESS;
                    r_sel   <= i_sel;
                end
                S_PRESS: begin
                    r_state <= S_HOLD;
                    r_cnt   <= '0;
                    r_rep   <= '0;
                end
                S_HOLD: begin
                    r_cnt <= w_cnt_nx;
                    if (!i_btn) r_state <= S_IDLE;
                    else if (w_hit) r_state <= S_AUTO;
                end
                S_AUTO: begin
                    r_cnt <= w_cnt_nx;
                    if (w_hit) r_state <= S_REP;
                    else if (!i_btn) r_state <= (LATCH_EN != 0) ? S_AUTO_L : S_IDLE;
                end
                S_REP: begin
                    r_cnt   <= w_cnt_nx;
                    r_rep   <= w_rep_nx;
                    r_state <= S_AUTO;
                end
                S_AUTO_L: begin
                    r_cnt <= w_cnt_nx;
                    if (w_hit) r_state <= S_REP_L;
                    else if (i_btn) r_state <= S_STOP;
                end
                S_REP_L: begin
                    r_cnt   <= w_cnt_nx;
                    r_rep   <= w_rep_nx;
                    r_state <= S_AUTO_L;
                end
                S_STOP: if (!i_btn) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/auto_repeat_ctrl.sv
// auto_repeat_ctrl: N_CH independent auto-repeat button channels driving per-target increment pulses.
module auto_repeat_ctrl
    import ar_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int N_TGT    = 2,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int SLOW_CYC = DEF_SLOW_CYC,
    parameter int FAST_CYC = DEF_FAST_CYC,
    parameter int ACCEL_N  = DEF_ACCEL_N,
    parameter int LATCH_EN = 1,
    localparam int SEL_W   = $clog2(N_TGT)
) (
    input  logic                  ck,
    input  logic                  reset,
    input  logic [N_CH-1:0]       btn,
    input  logic [N_CH*SEL_W-1:0] sel,
    input  logic [N_CH-1:0]       carry_in,
    output logic [N_CH*N_TGT-1:0] up,
    output logic [N_CH-1:0]       auto_on
);
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ar_channel #(
            .N_TGT(N_TGT), .SEL_W(SEL_W), .HOLD_CYC(HOLD_CYC), .SLOW_CYC(SLOW_CYC),
            .FAST_CYC(FAST_CYC), .ACCEL_N(ACCEL_N), .LATCH_EN(LATCH_EN)
        ) u_ch (
            .i_clk    (ck),
            .i_rst_n  (reset),
            .i_btn    (btn[c]),
            .i_sel    (sel[c*SEL_W +: SEL_W]),
            .i_carry  (carry_in[c]),
            .o_up     (up[c*N_TGT +: N_TGT]),
            .o_auto_on(auto_on[c])
        );
    end
endmodule
